tag_demux_fifo: RTL and testbench
=================================

TAG_DEMUX_FIFO -- requirements
Module: tag_demux_fifo

Interface
REQ-001 SHALL have parameter FLUX, default 2: number of flows; legal range ≥2.
REQ-002 SHALL have parameter WIDTH, default 8: tagged token width.
REQ-003 SHALL have parameter DEPTH, default 4: per-flow FIFO depth; power of two, ≥2.
REQ-004 SHALL derive TAG_WIDTH=$clog2(FLUX) and PW=WIDTH-TAG_WIDTH (payload width).
REQ-005 ck  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 in0_wr  input  1  upstream write strobe.
REQ-008 in0_data  input  WIDTH  token; tag = bits [WIDTH-1:PW], payload = bits [PW-1:0].
REQ-009 in0_full  output  1  backpressure to upstream.
REQ-010 out_data  output  PW*FLUX  head payload per flow; flow f at bits [f*PW +: PW].
REQ-011 out_empty  output  FLUX  bit f high = flow f FIFO empty.
REQ-012 out_read  input  FLUX  bit f pops flow f head.
REQ-013 drop_cnt  output  8  count of tokens dropped for illegal tag.

Function
REQ-014 SHALL hold one FIFO per flow (DEPTH×PW storage, read pointer, write pointer, occupancy counter 0..DEPTH).
REQ-015 in0_full SHALL be combinational OR of all per-flow full flags (occupancy==DEPTH); SHALL NOT depend on in0_data (upstream selects tag using in0_full, so no loop allowed).
REQ-016 Write accepted when in0_wr=1 and in0_full=0; write with in0_full=1 SHALL be ignored, no state change.
REQ-017 Accepted token with tag<FLUX SHALL store payload (tag stripped) at tail of FIFO[tag]; write pointer wraps DEPTH-1→0.
REQ-018 Accepted token with tag≥FLUX (only possible when FLUX not power of two) SHALL be discarded; drop_cnt increments, saturating at 255.
REQ-019 out_data for flow f SHALL be first-word-fall-through: head entry driven combinationally from storage; undefined content when empty is permitted but SHALL be stable.
REQ-020 out_empty[f] SHALL be combinational (occupancy==0).
REQ-021 out_read[f]=1 with out_empty[f]=0 SHALL pop head; read pointer wraps; out_read[f]=1 while empty SHALL be ignored.
REQ-022 Latency: token accepted at edge N SHALL be visible on out_data/out_empty after edge N (one cycle).
REQ-023 Simultaneous accepted write and read on same flow SHALL leave occupancy unchanged and preserve FIFO order; on different flows each proceeds independently.
REQ-024 Reads on all flows in same cycle SHALL all be honoured.
REQ-025 No bypass: write into empty FIFO SHALL NOT be readable in the same cycle.
REQ-026 Pop of last entry of a full flow at edge N SHALL deassert in0_full after edge N (if no other flow full).

Reset
REQ-027 rst=0 SHALL asynchronously clear all pointers, occupancy counters and drop_cnt; storage contents need not be cleared.
REQ-028 During reset: out_empty=all ones, in0_full=0, drop_cnt=0; in0_wr and out_read ignored.
REQ-029 Reset asserted mid-operation SHALL discard all buffered tokens; first edge after release behaves as from empty.

Verification (FLUX=2, WIDTH=8, DEPTH=4 unless stated; PW=7, tag=bit 7)
REQ-030 Reset: pulse rst low with random inputs -> out_empty=2'b11, in0_full=0, drop_cnt=0, asynchronously without clock edge.
REQ-031 Routing: write 0x85 -> next cycle out_empty=2'b01, out_data[13:7]=0x05; pulse out_read=2'b10 -> out_empty=2'b11.
REQ-032 Full: write 0x01,0x02,0x03,0x04 -> in0_full=1; write 0x85 ignored, out_empty[1] stays 1; read flow 0 -> out_data[6:0]=0x01 then in0_full=0, next head 0x02.
REQ-033 Concurrent: flow 0 holds 0x0A,0x0B; same cycle write 0x0C and read flow 0 -> occupancy 2, pops yield 0x0B,0x0C in order; wrap exercised over ≥2 pointer laps.
REQ-034 Illegal tag: FLUX=3, WIDTH=8 (PW=6), write 0xC1 -> all flows empty, drop_cnt=1; 256 such writes -> drop_cnt=255.
REQ-035 Reset mid-operation: flows with 3 and 1 entries, assert rst between edges -> out_empty=2'b11 immediately; after release write 0x03 -> head of flow 0 = 0x03.

Source files
------------

// File: rtl/tag_demux_fifo_if.sv
// Bus bundle for tag_demux_fifo: tagged token input with backpressure and
// per-flow first-word-fall-through outputs.
interface tag_demux_fifo_if #(
  parameter int unsigned FLUX  = 2,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned TAG_WIDTH = $clog2(FLUX);
  localparam int unsigned PW        = WIDTH - TAG_WIDTH;

  logic                 in0_wr;
  logic [WIDTH-1:0]     in0_data;
  logic                 in0_full;
  logic [PW*FLUX-1:0]   out_data;
  logic [FLUX-1:0]      out_empty;
  logic [FLUX-1:0]      out_read;
  logic [7:0]           drop_cnt;

  modport master (
    output in0_wr, in0_data, out_read,
    input  in0_full, out_data, out_empty, drop_cnt
  );

  modport slave (
    input  in0_wr, in0_data, out_read,
    output in0_full, out_data, out_empty, drop_cnt
  );
endinterface

// File: rtl/tag_demux_fifo.sv
// Routes tagged tokens into one FIFO per flow by tag; tokens with an
// out-of-range tag are counted and discarded.
module tag_demux_fifo #(
  parameter int unsigned FLUX  = 2,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic             ck,
  input logic             rst,
  tag_demux_fifo_if.slave bus
);
  localparam int unsigned TAG_WIDTH = $clog2(FLUX);
  localparam int unsigned PW        = WIDTH - TAG_WIDTH;
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned CNT_W     = AW + 1;

  logic [PW-1:0]        mem_q    [FLUX][DEPTH];
  logic [AW-1:0]        rd_ptr_q [FLUX];
  logic [AW-1:0]        rd_ptr_d [FLUX];
  logic [AW-1:0]        wr_ptr_q [FLUX];
  logic [AW-1:0]        wr_ptr_d [FLUX];
  logic [CNT_W-1:0]     cnt_q    [FLUX];
  logic [CNT_W-1:0]     cnt_d    [FLUX];
  logic [7:0]           drop_q, drop_d;

  logic [TAG_WIDTH-1:0] tag;
  logic [PW-1:0]        payload;
  logic                 tag_legal;
  logic                 wr_ok;
  logic [FLUX-1:0]      full_flag;
  logic [FLUX-1:0]      push;
  logic [FLUX-1:0]      pop;

  assign tag       = bus.in0_data[WIDTH-1:PW];
  assign payload   = bus.in0_data[PW-1:0];
  assign tag_legal = {{(32-TAG_WIDTH){1'b0}}, tag} < FLUX;

  // Full depends only on occupancy so upstream may pick its tag from it.
  always_comb begin
    full_flag     = '0;
    bus.out_empty = '0;
    for (int f = 0; f < FLUX; f++) begin
      full_flag[f]     = (cnt_q[f] == CNT_W'(DEPTH));
      bus.out_empty[f] = (cnt_q[f] == '0);
    end
  end

  assign bus.in0_full = |full_flag;
  assign wr_ok        = bus.in0_wr & ~bus.in0_full;
  assign bus.drop_cnt = drop_q;

  always_comb begin
    push = '0;
    pop  = '0;
    for (int f = 0; f < FLUX; f++) begin
      push[f] = wr_ok & tag_legal & (tag == TAG_WIDTH'(f));
      pop[f]  = bus.out_read[f] & ~bus.out_empty[f];
    end
  end

  always_comb begin
    for (int f = 0; f < FLUX; f++) begin
      rd_ptr_d[f] = rd_ptr_q[f];
      wr_ptr_d[f] = wr_ptr_q[f];
      cnt_d[f]    = cnt_q[f];
      if (pop[f]) begin
        rd_ptr_d[f] = rd_ptr_q[f] + AW'(1);
      end
      if (push[f]) begin
        wr_ptr_d[f] = wr_ptr_q[f] + AW'(1);
      end
      if (push[f] && !pop[f]) begin
        cnt_d[f] = cnt_q[f] + CNT_W'(1);
      end else if (!push[f] && pop[f]) begin
        cnt_d[f] = cnt_q[f] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (wr_ok && !tag_legal && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      for (int f = 0; f < FLUX; f++) begin
        rd_ptr_q[f] <= '0;
        wr_ptr_q[f] <= '0;
        cnt_q[f]    <= '0;
      end
      drop_q <= '0;
    end else begin
      for (int f = 0; f < FLUX; f++) begin
        rd_ptr_q[f] <= rd_ptr_d[f];
        wr_ptr_q[f] <= wr_ptr_d[f];
        cnt_q[f]    <= cnt_d[f];
      end
      drop_q <= drop_d;
    end
  end

  // Storage is left uninitialised; occupancy alone defines validity.
  always_ff @(posedge ck) begin
    for (int f = 0; f < FLUX; f++) begin
      if (push[f]) begin
        mem_q[f][wr_ptr_q[f]] <= payload;
      end
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int f = 0; f < FLUX; f++) begin
      bus.out_data[f*PW +: PW] = mem_q[f][rd_ptr_q[f]];
    end
  end
endmodule

// File: tb/tb_tag_demux_fifo.sv
// Randomised bench for tag_demux_fifo: a 2-flow and a 3-flow instance, each
// checked every cycle against queue-based flow models plus directed cases.
module tb_tag_demux_fifo;
  localparam int DEPTH = 4;

  logic ck;
  logic rst;

  tag_demux_fifo_if #(.FLUX(2), .WIDTH(8)) bus_a ();
  tag_demux_fifo_if #(.FLUX(3), .WIDTH(8)) bus_b ();

  tag_demux_fifo #(.FLUX(2), .WIDTH(8), .DEPTH(DEPTH)) dut_a (
    .ck  (ck),
    .rst (rst),
    .bus (bus_a)
  );

  tag_demux_fifo #(.FLUX(3), .WIDTH(8), .DEPTH(DEPTH)) dut_b (
    .ck  (ck),
    .rst (rst),
    .bus (bus_b)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Flows 0..1 model instance a, flows 2..4 model instance b.
  logic [7:0] mq [5][$];
  int drop_a;
  int drop_b;
  int total;
  int passed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input int base, input int flux, input int pw, input logic wr,
                            input logic [7:0] data, input logic [2:0] rd, inout int drop);
    bit   full;
    bit   pop [3];
    int   tag;
    logic [7:0] pay;
    full = 0;
    for (int f = 0; f < flux; f++) if (mq[base+f].size() == DEPTH) full = 1;
    for (int f = 0; f < flux; f++) pop[f] = rd[f] && (mq[base+f].size() > 0);
    for (int f = 0; f < flux; f++) if (pop[f]) void'(mq[base+f].pop_front());
    if (wr && !full) begin
      tag = int'(data >> pw);
      pay = data & ((8'd1 << pw) - 8'd1);
      if (tag < flux) mq[base+tag].push_back(pay);
      else if (drop < 255) drop++;
    end
  endtask

  always @(posedge ck or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 5; i++) mq[i].delete();
      drop_a = 0;
      drop_b = 0;
    end else begin
      model_step(0, 2, 7, bus_a.in0_wr, bus_a.in0_data, {1'b0, bus_a.out_read}, drop_a);
      model_step(2, 3, 6, bus_b.in0_wr, bus_b.in0_data, bus_b.out_read, drop_b);
    end
  end

  task automatic compare_inst(input string nm, input int base, input int flux, input int pw,
                              input logic [20:0] odata, input logic [2:0] oempty,
                              input logic ofull, input logic [7:0] odrop, input int drop);
    bit full;
    logic [20:0] mask;
    full = 0;
    mask = (21'd1 << pw) - 21'd1;
    for (int f = 0; f < flux; f++) begin
      if (mq[base+f].size() == DEPTH) full = 1;
      check({nm, "_empty"}, 32'(oempty[f]), 32'(mq[base+f].size() == 0));
      if (mq[base+f].size() > 0)
        check({nm, "_head"}, 32'((odata >> (f*pw)) & mask), 32'(mq[base+f][0]));
    end
    check({nm, "_full"}, 32'(ofull), 32'(full));
    check({nm, "_drop"}, 32'(odrop), 32'(drop));
  endtask

  always @(negedge ck) begin
    compare_inst("a", 0, 2, 7, {7'b0, bus_a.out_data}, {1'b0, bus_a.out_empty},
                 bus_a.in0_full, bus_a.drop_cnt, drop_a);
    compare_inst("b", 2, 3, 6, {3'b0, bus_b.out_data}, bus_b.out_empty,
                 bus_b.in0_full, bus_b.drop_cnt, drop_b);
  end

  task automatic cyc();
    @(posedge ck);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.in0_wr = 0; bus_a.in0_data = '0; bus_a.out_read = '0;
    bus_b.in0_wr = 0; bus_b.in0_data = '0; bus_b.out_read = '0;
  endtask

  task automatic rand_inputs(input int rd_pct);
    bus_a.in0_wr   = 1'($urandom_range(0, 1));
    bus_a.in0_data = 8'($urandom);
    bus_a.out_read = {1'($urandom_range(0, 99) < rd_pct), 1'($urandom_range(0, 99) < rd_pct)};
    bus_b.in0_wr   = 1'($urandom_range(0, 1));
    bus_b.in0_data = 8'($urandom);
    bus_b.out_read = {1'($urandom_range(0, 99) < rd_pct), 1'($urandom_range(0, 99) < rd_pct),
                      1'($urandom_range(0, 99) < rd_pct)};
  endtask

  task automatic wr_a(input logic [7:0] d);
    bus_a.in0_wr = 1; bus_a.in0_data = d;
    cyc();
    bus_a.in0_wr = 0;
  endtask

  task automatic rd_a(input logic [1:0] m);
    bus_a.out_read = m;
    cyc();
    bus_a.out_read = '0;
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1;
    idle_inputs();

    // Asynchronous reset with garbage inputs, before any clock edge.
    #3 rst = 0;
    rand_inputs(50);
    #1;
    check("rst_empty_a", 32'(bus_a.out_empty), 32'h3);
    check("rst_full_a", 32'(bus_a.in0_full), 32'h0);
    check("rst_drop_a", 32'(bus_a.drop_cnt), 32'h0);
    check("rst_empty_b", 32'(bus_b.out_empty), 32'h7);
    repeat (2) begin
      cyc();
      rand_inputs(50);
    end
    #1;
    check("rst_hold_empty_a", 32'(bus_a.out_empty), 32'h3);
    idle_inputs();
    cyc();
    rst = 1;

    // Routing to flow 1.
    wr_a(8'h85);
    check("route_empty", 32'(bus_a.out_empty), 32'h1);
    check("route_data", 32'(bus_a.out_data[13:7]), 32'h05);
    rd_a(2'b10);
    check("route_pop_empty", 32'(bus_a.out_empty), 32'h3);

    // Fill flow 0, blocked write, pop frees space.
    wr_a(8'h01); wr_a(8'h02); wr_a(8'h03); wr_a(8'h04);
    check("full_set", 32'(bus_a.in0_full), 32'h1);
    check("full_head", 32'(bus_a.out_data[6:0]), 32'h01);
    wr_a(8'h85);
    check("full_ignored", 32'(bus_a.out_empty[1]), 32'h1);
    rd_a(2'b01);
    check("full_clear", 32'(bus_a.in0_full), 32'h0);
    check("full_next_head", 32'(bus_a.out_data[6:0]), 32'h02);
    repeat (3) rd_a(2'b01);
    check("full_drained", 32'(bus_a.out_empty), 32'h3);

    // Concurrent write and read on flow 0.
    wr_a(8'h0A); wr_a(8'h0B);
    bus_a.in0_wr = 1; bus_a.in0_data = 8'h0C; bus_a.out_read = 2'b01;
    cyc();
    idle_inputs();
    check("conc_occ_model", 32'(mq[0].size()), 32'd2);
    check("conc_head0", 32'(bus_a.out_data[6:0]), 32'h0B);
    rd_a(2'b01);
    check("conc_head1", 32'(bus_a.out_data[6:0]), 32'h0C);
    rd_a(2'b01);
    check("conc_empty", 32'(bus_a.out_empty), 32'h3);

    // Illegal tag on the 3-flow instance, then saturation.
    bus_b.in0_wr = 1; bus_b.in0_data = 8'hC1;
    cyc();
    bus_b.in0_wr = 0;
    check("drop_empty", 32'(bus_b.out_empty), 32'h7);
    check("drop_one", 32'(bus_b.drop_cnt), 32'd1);
    bus_b.in0_wr = 1;
    repeat (256) cyc();
    bus_b.in0_wr = 0;
    check("drop_sat", 32'(bus_b.drop_cnt), 32'd255);

    // Reset between edges with buffered tokens.
    wr_a(8'h01); wr_a(8'h02); wr_a(8'h03); wr_a(8'h81);
    check("mid_pre_empty", 32'(bus_a.out_empty), 32'h0);
    #2 rst = 0;
    #1;
    check("mid_rst_empty", 32'(bus_a.out_empty), 32'h3);
    check("mid_rst_full", 32'(bus_a.in0_full), 32'h0);
    check("mid_rst_drop_b", 32'(bus_b.drop_cnt), 32'h0);
    cyc();
    rst = 1;
    wr_a(8'h03);
    check("mid_after_head", 32'(bus_a.out_data[6:0]), 32'h03);
    check("mid_after_empty", 32'(bus_a.out_empty), 32'h2);

    // Random traffic, alternating read pressure, occasional async reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 0;
        #2 rst = 1;
      end
      rand_inputs(((i / 200) % 2 == 0) ? 25 : 70);
      cyc();
    end
    idle_inputs();
    repeat (2) cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
